// File: rtl/mem_if_if.sv
// Memory-side port of the LC-3 memory sequencer: enable/write/address/data out,
// read data and ready back. The sequencer is the master, the memory the slave.
interface mem_if_if #(
  parameter int W  = 16,
  parameter int AW = 16
) ();
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_wdata_o;
  logic [W-1:0]  mem_rdata_i;
  logic          mem_ready_i;

  modport master (
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport slave (
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/mem_if.sv
// LC-3 memory access sequencer: IDLE -> ACCESS -> DONE, feeds the MDR load strobe/data.
// Optional wait-state timeout compiled in with `define MEM_IF_TIMEOUT_EN.
module mem_if #(
  parameter int W       = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          ld_en_o,
  output logic [W-1:0]  rdata_o,
  output logic          err_o,
  mem_if_if.master      mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic [W-1:0]  rdata_q, rdata_d;

`ifdef MEM_IF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_IF_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
`ifdef MEM_IF_TIMEOUT_EN
          cnt_d   = '0;
          to_d    = 1'b0;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // ready has priority over an expiring timeout in the same cycle
        if (mem.mem_ready_i) begin
          if (!we_q) rdata_d = mem.mem_rdata_i;
          state_d = DONE;
        end
`ifdef MEM_IF_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT)) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_IF_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_IF_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // All outputs decode registered state only; bus is forced to 0 outside ACCESS.
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign rdata_o         = rdata_q;
  assign mem.mem_en_o    = (state_q == ACCESS);
  assign mem.mem_we_o    = (state_q == ACCESS) && we_q;
  assign mem.mem_addr_o  = (state_q == ACCESS) ? addr_q  : '0;
  assign mem.mem_wdata_o = (state_q == ACCESS) ? wdata_q : '0;

`ifdef MEM_IF_TIMEOUT_EN
  assign ld_en_o = (state_q == DONE) && !we_q && !to_q;
  assign err_o   = (state_q == DONE) && to_q;
`else
  assign ld_en_o = (state_q == DONE) && !we_q;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_if.sv
// Bench for mem_if: transaction-level model (expected bus image per access, last read value,
// downstream MDR contents) driven with directed and $urandom accesses.
module tb_mem_if;
  localparam int W = 16, AW = 16, TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req, we;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic          busy, done, ld_en, err;
  logic [W-1:0]  rdata;
  logic [W-1:0]  mdr = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_rdata = '0;
  logic [W-1:0] exp_mdr   = '0;

  mem_if_if #(.W(W), .AW(AW)) bus ();

  mem_if #(.W(W), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .ld_en_o(ld_en), .rdata_o(rdata), .err_o(err),
    .mem(bus.master)
  );

  always #5 clk = ~clk;

  // downstream MDR register fed by the sequencer
  always @(posedge clk) if (ld_en) mdr <= rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en"},    bus.mem_en_o, 0);
    chk({tag, "_we"},    bus.mem_we_o, 0);
    chk({tag, "_addr"},  bus.mem_addr_o, 0);
    chk({tag, "_wdata"}, bus.mem_wdata_o, 0);
  endtask

  // One access: accept, (waits) cycles without ready, one cycle with ready, DONE, IDLE.
  task automatic do_txn(input logic t_we, input logic [AW-1:0] a, input logic [W-1:0] wd,
                        input int waits, input logic [W-1:0] rd, input bit poke);
    req = 1'b1; we = t_we; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = AW'($urandom); wdata = W'($urandom);
    for (int i = 0; i <= waits; i++) begin
      chk("acc_busy",  busy, 1);
      chk("acc_en",    bus.mem_en_o, 1);
      chk("acc_we",    bus.mem_we_o, t_we);
      chk("acc_addr",  bus.mem_addr_o, a);
      chk("acc_wdata", bus.mem_wdata_o, wd);
      chk("acc_done",  done, 0);
      if (poke && i == 0 && waits > 0) begin req = 1'b1; addr = 16'h5555; end
      else req = 1'b0;
      bus.mem_ready_i = (i == waits);
      bus.mem_rdata_i = (i == waits) ? rd : W'($urandom);
      @(negedge clk);
    end
    req = 1'b0;
    bus.mem_ready_i = 1'($urandom);
    bus.mem_rdata_i = W'($urandom);
    if (!t_we) begin exp_rdata = rd; exp_mdr = rd; end
    chk("dn_done",  done, 1);
    chk("dn_ld",    ld_en, !t_we);
    chk("dn_err",   err, 0);
    chk("dn_busy",  busy, 1);
    chk("dn_rdata", rdata, exp_rdata);
    chk_quiet("dn");
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    chk("id_done",  done, 0);
    chk("id_ld",    ld_en, 0);
    chk("id_busy",  busy, 0);
    chk("id_rdata", rdata, exp_rdata);
    chk("id_mdr",   mdr, exp_mdr);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b1; we = 1'b1; addr = 16'hFFFF; wdata = 16'hFFFF;
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 16'hAAAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ld", ld_en, 0);
    chk("rst_err", err, 0);   chk("rst_rdata", rdata, 0);
    chk_quiet("rst");
    rst_n = 1'b1; req = 1'b0; bus.mem_ready_i = 1'b0;
    @(negedge clk);

    do_txn(1'b0, 16'h3000, 16'h0000, 0, 16'hBEEF, 1'b0);
    chk("mdr_beef", mdr, 16'hBEEF);
    do_txn(1'b1, 16'h4000, 16'h1234, 3, 16'h0000, 1'b0);
    do_txn(1'b0, 16'h3001, 16'h0000, 2, 16'hC0DE, 1'b1);

    // reset abandons an access during its second wait cycle
    req = 1'b1; we = 1'b0; addr = 16'h3002;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("mr_en", bus.mem_en_o, 1);
    rst_n = 1'b0; bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 16'h7777;
    @(negedge clk);
    exp_rdata = '0;
    rst_n = 1'b1;
    chk("mr_busy", busy, 0); chk("mr_done", done, 0); chk("mr_ld", ld_en, 0);
    chk("mr_rdata", rdata, exp_rdata);
    chk_quiet("mr");
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    chk("mr2_done", done, 0); chk("mr2_ld", ld_en, 0); chk("mr2_busy", busy, 0);
    chk("mr2_mdr", mdr, exp_mdr);

    // randomized accesses with idle gaps; spurious ready/data in IDLE must be ignored
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.mem_ready_i = 1'($urandom); bus.mem_rdata_i = W'($urandom);
        @(negedge clk);
        chk("gap_done", done, 0); chk("gap_busy", busy, 0);
      end
      bus.mem_ready_i = 1'b0;
      do_txn(1'($urandom), AW'($urandom), W'($urandom), $urandom_range(0, TO),
             W'($urandom), 1'($urandom));
    end

`ifdef MEM_IF_TIMEOUT_EN
    // counter reaches TIMEOUT with no ready: error completion, MDR not loaded
    req = 1'b1; we = 1'b0; addr = 16'h3100;
    @(negedge clk);
    req = 1'b0; bus.mem_ready_i = 1'b0;
    for (int i = 0; i <= TO; i++) begin
      chk("to_en", bus.mem_en_o, 1); chk("to_done_early", done, 0);
      @(negedge clk);
    end
    chk("to_err", err, 1); chk("to_done", done, 1); chk("to_ld", ld_en, 0);
    chk("to_rdata", rdata, exp_rdata);
    @(negedge clk);
    chk("to_idle_busy", busy, 0); chk("to_idle_err", err, 0); chk("to_mdr", mdr, exp_mdr);
`else
    // no timeout built: ACCESS waits as long as the memory does
    req = 1'b1; we = 1'b0; addr = 16'h3100;
    @(negedge clk);
    req = 1'b0; bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("nt_busy", busy, 1); chk("nt_err", err, 0); chk("nt_done", done, 0);
      @(negedge clk);
    end
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 16'h5A5A;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    exp_rdata = 16'h5A5A; exp_mdr = 16'h5A5A;
    chk("nt_fin_done", done, 1); chk("nt_fin_ld", ld_en, 1); chk("nt_fin_err", err, 0);
    chk("nt_fin_rdata", rdata, exp_rdata);
    @(negedge clk);
    chk("nt_mdr", mdr, exp_mdr);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_if.md
# mem_if

Memory access sequencer for the LC-3 datapath. Accepts one read or write request from the control unit, drives a ready/handshake memory port, and on read completion produces the load strobe and data that feed the downstream MDR `register` (its `wr_en`/`d_i`). It also raises the LC-3 `R` (memory-ready) condition back to the control FSM.

## Interface
- `W`, 16, data width.
- `AW`, 16, address width.
- `TIMEOUT`, 15, maximum cycles spent waiting for `mem_ready_i`; only used when the timeout is compiled in. Must be at least 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `req_i`  in  1  access request; sampled only in IDLE.
- `we_i`  in  1  1 = write, 0 = read; sampled with `req_i`.
- `addr_i`  in  AW  access address (MAR value).
- `wdata_i`  in  W  write data (MDR value).
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle completion pulse (LC-3 `R`).
- `ld_en_o`  out  1  one-cycle load strobe to the MDR register; reads only.
- `rdata_o`  out  W  captured read data; drives the MDR register `d_i`.
- `err_o`  out  1  one-cycle timeout flag, coincident with `done_o`.
- `mem_en_o`  out  1  memory access enable.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  AW  memory address.
- `mem_wdata_o`  out  W  memory write data.
- `mem_rdata_i`  in  W  memory read data; valid when `mem_ready_i`=1.
- `mem_ready_i`  in  1  memory completion; sampled only in ACCESS.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE:**
  - If `req_i`=1, latch `addr_i`, `wdata_i` and `we_i` into internal registers.
  - Clear the wait counter and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS:**
  - `mem_en_o`=1; `mem_we_o` = latched `we`; `mem_addr_o`/`mem_wdata_o` = latched values.
  - Latched values are held stable for the whole ACCESS state.
  - If `mem_ready_i`=1:
    - On a read, capture `mem_rdata_i` into `rdata_o`.
    - Go to DONE.
  - Else increment the wait counter.
- **DONE:**
  - `done_o`=1.
  - `ld_en_o`=1 only if the access was a read and did not time out.
  - `mem_en_o`=0.
  - Unconditionally go to IDLE.
- `req_i` in ACCESS or DONE is ignored; it is not queued. The requester must hold `req_i` until it sees `busy_o`, or re-assert it after `done_o`.
- `rdata_o` holds its last captured value until the next successful read. Writes never modify it.
- Outside ACCESS, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are 0.
- **Reset** (`rst_n`=0 at a rising edge), from any state:
  - State goes to IDLE; the wait counter and latched registers are cleared.
  - `rdata_o`=0.
  - All outputs are 0 in the following cycle.
- **Reset mid-ACCESS:** the access is abandoned. No `done_o` or `ld_en_o` is produced; `mem_en_o` drops after that edge.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from an input to an output.
- Request accepted at edge k → ACCESS from edge k; `mem_en_o` high starting in cycle k.
- `mem_ready_i` sampled high at edge k+m (m ≥ 1) → DONE after edge k+m. `done_o`/`ld_en_o` are high for exactly one cycle, then IDLE after edge k+m+1.
- Minimum latency: request to `done_o` is 2 edges. Minimum spacing between accepted requests is 3 edges.
- **MDR contract:** `rdata_o` is stable in the cycle `ld_en_o` is high, so the MDR register captures it at edge k+m+1.
- `mem_ready_i` outside ACCESS is ignored.

## Configuration
- Macro: `MEM_IF_TIMEOUT_EN`.
- **Defined:**
  - The wait counter is ceil(log2(TIMEOUT+1)) bits wide.
  - If the counter reaches `TIMEOUT` in ACCESS with `mem_ready_i`=0, go to DONE with `err_o`=1, `done_o`=1, `ld_en_o`=0; `rdata_o` is unchanged.
  - If `mem_ready_i`=1 in that same cycle, ready wins and no error is raised.
- **Undefined:**
  - No counter is built; ACCESS waits indefinitely.
  - `err_o` is tied to 0.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 edges with `req_i`=1 → all outputs 0, `busy_o`=0, `rdata_o`=0.
- **Zero-wait read:** `req_i`=1, `we_i`=0, `addr_i`=16'h3000; memory returns 16'hBEEF with `mem_ready_i` at the first ACCESS edge → `done_o` and `ld_en_o` high together for one cycle, `rdata_o`=16'hBEEF; an MDR `register` driven by these outputs reads 16'hBEEF afterwards.
- **Write with 3 wait cycles:** `we_i`=1, `addr_i`=16'h4000, `wdata_i`=16'h1234 → `mem_en_o`/`mem_we_o` high for 4 cycles with the address and data stable; `done_o` pulses once, `ld_en_o`=0, `rdata_o` unchanged.
- **Ignored request:** pulse `req_i` with `addr_i`=16'h5555 during ACCESS of a read to 16'h3001 → only 16'h3001 appears on `mem_addr_o`; exactly one `done_o`.
- **Reset mid-operation:** assert `rst_n`=0 during the 2nd wait cycle of a read → IDLE, no `done_o`/`ld_en_o`, `mem_en_o`=0 after the reset edge.
- **Timeout (with `MEM_IF_TIMEOUT_EN`, `TIMEOUT`=4):** hold `mem_ready_i`=0 → `err_o`=`done_o`=1 after 4 wait cycles, `ld_en_o`=0, `rdata_o` retains its previous value. Without the macro: `busy_o` stays 1 for 50 cycles and `err_o` is never asserted.
